// File: rtl/dbg_pwm_pkg.sv
// ============================================================================
//  Module   : dbg_pwm_pkg
//  Purpose  : Register map, CTRL/STATUS bit positions for the pulse-width monitor.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package dbg_pwm_pkg;

  localparam int C_MAX_CH = 16;

  localparam logic [7:0] C_ADDR_CTRL    = 8'h00;
  localparam logic [7:0] C_ADDR_CH_SEL  = 8'h01;
  localparam logic [7:0] C_ADDR_STATUS  = 8'h02;
  localparam logic [7:0] C_ADDR_HI_NUM  = 8'h03;
  localparam logic [7:0] C_ADDR_LO_NUM  = 8'h04;
  localparam logic [7:0] C_ADDR_HI_HIST = 8'h10;
  localparam logic [7:0] C_ADDR_LO_HIST = 8'h20;
  localparam logic [7:0] C_ADDR_MINMAX  = 8'h30;

  localparam int C_CTRL_CLR    = 0;
  localparam int C_CTRL_FREEZE = 1;

  localparam int C_STAT_LEVEL  = 2;
  localparam int C_STAT_HI_OVF = 4;
  localparam int C_STAT_LO_OVF = 5;
  localparam int C_STAT_HI_ARM = 6;
  localparam int C_STAT_LO_ARM = 7;

endpackage

`default_nettype wire

// File: rtl/dbg_pwm_chan.sv
// ============================================================================
//  Module   : dbg_pwm_chan
//  Purpose  : One channel: synchroniser, edge detect, width counters, history,
//             min/max and entry counts for both polarities.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dbg_pwm_chan
  import dbg_pwm_pkg::*;
#(
  parameter int CNT_W       = 12,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_sig,
  input  logic                          i_clr,
  input  logic                          i_freeze,
  output logic [7:0]                    o_status,
  output logic [3:0]                    o_hi_num,
  output logic [3:0]                    o_lo_num,
  output logic [DEPTH-1:0][CNT_W-1:0]   o_hi_hist,
  output logic [DEPTH-1:0][CNT_W-1:0]   o_lo_hist,
  output logic [CNT_W-1:0]              o_hi_max,
  output logic [CNT_W-1:0]              o_hi_min,
  output logic [CNT_W-1:0]              o_lo_max,
  output logic [CNT_W-1:0]              o_lo_min
);

  localparam logic [CNT_W-1:0] C_SAT   = '1;
  localparam logic [3:0]       C_DEPTH = 4'(DEPTH);

  logic [SYNC_STAGES-1:0]      r_sync;
  logic                        r_prev;
  logic                        w_level, w_rise, w_fall, w_hi_push, w_lo_push;
  logic [CNT_W-1:0]            r_hi_cnt, r_lo_cnt;
  logic                        r_hi_ovf, r_lo_ovf, r_hi_arm, r_lo_arm;
  logic [3:0]                  r_hi_num, r_lo_num;
  logic [DEPTH-1:0][CNT_W-1:0] r_hi_hist, r_lo_hist;
  logic [CNT_W-1:0]            r_hi_max, r_hi_min, r_lo_max, r_lo_min;

  assign w_level = r_sync[SYNC_STAGES-1];
  assign w_rise  = w_level & ~r_prev;
  assign w_fall  = ~w_level & r_prev;
  // A clear in the same cycle as an edge discards that edge's capture
  assign w_hi_push = w_fall & r_hi_arm & ~i_clr & ~i_freeze;
  assign w_lo_push = w_rise & r_lo_arm & ~i_clr & ~i_freeze;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
      r_prev <= w_level;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_hi_cnt <= '0;
      r_lo_cnt <= '0;
      r_hi_ovf <= 1'b0;
      r_lo_ovf <= 1'b0;
      r_hi_arm <= 1'b0;
      r_lo_arm <= 1'b0;
    end else begin
      if (w_rise) begin
        r_hi_cnt <= CNT_W'(1);
        r_hi_arm <= 1'b1;
      end else if (w_level && r_hi_cnt != C_SAT) begin
        r_hi_cnt <= r_hi_cnt + 1'b1;
      end
      if (w_fall) begin
        r_lo_cnt <= CNT_W'(1);
        r_lo_arm <= 1'b1;
      end else if (!w_level && r_lo_cnt != C_SAT) begin
        r_lo_cnt <= r_lo_cnt + 1'b1;
      end
      if (r_hi_cnt == C_SAT) r_hi_ovf <= 1'b1;
      if (r_lo_cnt == C_SAT) r_lo_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_hi_hist <= '0;
      r_lo_hist <= '0;
      r_hi_num  <= '0;
      r_lo_num  <= '0;
      r_hi_max  <= '0;
      r_lo_max  <= '0;
      r_hi_min  <= C_SAT;
      r_lo_min  <= C_SAT;
    end else begin
      if (w_hi_push) begin
        for (int i = DEPTH - 1; i > 0; i--) r_hi_hist[i] <= r_hi_hist[i-1];
        r_hi_hist[0] <= r_hi_cnt;
        if (r_hi_num != C_DEPTH) r_hi_num <= r_hi_num + 4'd1;
        if (r_hi_cnt > r_hi_max) r_hi_max <= r_hi_cnt;
        if (r_hi_cnt < r_hi_min) r_hi_min <= r_hi_cnt;
      end
      if (w_lo_push) begin
        for (int i = DEPTH - 1; i > 0; i--) r_lo_hist[i] <= r_lo_hist[i-1];
        r_lo_hist[0] <= r_lo_cnt;
        if (r_lo_num != C_DEPTH) r_lo_num <= r_lo_num + 4'd1;
        if (r_lo_cnt > r_lo_max) r_lo_max <= r_lo_cnt;
        if (r_lo_cnt < r_lo_min) r_lo_min <= r_lo_cnt;
      end
    end
  end

  always_comb begin
    o_status                = '0;
    o_status[C_STAT_LEVEL]  = w_level;
    o_status[C_STAT_HI_OVF] = r_hi_ovf;
    o_status[C_STAT_LO_OVF] = r_lo_ovf;
    o_status[C_STAT_HI_ARM] = r_hi_arm;
    o_status[C_STAT_LO_ARM] = r_lo_arm;
  end

  assign o_hi_num  = r_hi_num;
  assign o_lo_num  = r_lo_num;
  assign o_hi_hist = r_hi_hist;
  assign o_lo_hist = r_lo_hist;
  assign o_hi_max  = r_hi_max;
  assign o_hi_min  = r_hi_min;
  assign o_lo_max  = r_lo_max;
  assign o_lo_min  = r_lo_min;

endmodule

`default_nettype wire

// File: rtl/dbg_pulse_width_mon.sv
// ============================================================================
//  Module   : dbg_pulse_width_mon
//  Purpose  : Multi-channel pulse-width debug monitor with byte-wide host port.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dbg_pulse_width_mon
  import dbg_pwm_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 12,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] iADDR,
  input  logic              iWE,
  input  logic              iRE,
  input  logic [7:0]        iDATA,
  output logic [7:0]        oRD,
  input  logic [N_CH-1:0]   iSIG
);

  logic [7:0]                  w_status  [C_MAX_CH];
  logic [3:0]                  w_hi_num  [C_MAX_CH];
  logic [3:0]                  w_lo_num  [C_MAX_CH];
  logic [DEPTH-1:0][CNT_W-1:0] w_hi_hist [C_MAX_CH];
  logic [DEPTH-1:0][CNT_W-1:0] w_lo_hist [C_MAX_CH];
  logic [CNT_W-1:0]            w_hi_max  [C_MAX_CH];
  logic [CNT_W-1:0]            w_hi_min  [C_MAX_CH];
  logic [CNT_W-1:0]            w_lo_max  [C_MAX_CH];
  logic [CNT_W-1:0]            w_lo_min  [C_MAX_CH];

  logic [15:0]                 w_addr;
  logic                        w_wr_ctrl, w_wr_chsel, w_clr;
  logic                        r_freeze;
  logic [7:0]                  r_ch_sel;
  logic [3:0]                  w_ch;
  logic                        w_ch_ok;
  logic [7:0][CNT_W-1:0]       w_hist8;
  logic [15:0]                 w_pair;
  logic                        w_is_pair, w_is_low, w_shadow_hit;
  logic [7:0]                  w_live;
  logic [7:0]                  r_shadow;
  logic [6:0]                  r_shadow_tag;
  logic                        r_shadow_vld;

  assign w_addr     = 16'(iADDR);
  assign w_wr_ctrl  = iWE && (w_addr == 16'(C_ADDR_CTRL));
  assign w_wr_chsel = iWE && (w_addr == 16'(C_ADDR_CH_SEL));
  assign w_clr      = w_wr_ctrl && iDATA[C_CTRL_CLR];
  assign w_ch       = r_ch_sel[3:0];
  assign w_ch_ok    = (r_ch_sel[7:4] == 4'h0);

  // Channel slots beyond N_CH are tied to zero so out-of-range selects read 0
  for (genvar c = 0; c < C_MAX_CH; c++) begin : g_ch
    if (c < N_CH) begin : g_mon
      dbg_pwm_chan #(
        .CNT_W       (CNT_W),
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SYNC_STAGES)
      ) u_chan (
        .clk       (CLK),
        .rst       (RST),
        .i_sig     (iSIG[c]),
        .i_clr     (w_clr),
        .i_freeze  (r_freeze),
        .o_status  (w_status[c]),
        .o_hi_num  (w_hi_num[c]),
        .o_lo_num  (w_lo_num[c]),
        .o_hi_hist (w_hi_hist[c]),
        .o_lo_hist (w_lo_hist[c]),
        .o_hi_max  (w_hi_max[c]),
        .o_hi_min  (w_hi_min[c]),
        .o_lo_max  (w_lo_max[c]),
        .o_lo_min  (w_lo_min[c])
      );
    end else begin : g_tie
      assign w_status[c]  = '0;
      assign w_hi_num[c]  = '0;
      assign w_lo_num[c]  = '0;
      assign w_hi_hist[c] = '0;
      assign w_lo_hist[c] = '0;
      assign w_hi_max[c]  = '0;
      assign w_hi_min[c]  = '0;
      assign w_lo_max[c]  = '0;
      assign w_lo_min[c]  = '0;
    end
  end

  always_comb begin
    w_live    = '0;
    w_pair    = '0;
    w_is_pair = 1'b0;
    w_hist8   = '0;
    for (int i = 0; i < DEPTH; i++)
      w_hist8[i] = w_addr[5] ? w_lo_hist[w_ch][i] : w_hi_hist[w_ch][i];
    if (w_addr[15:8] == 8'h00) begin
      case (w_addr[7:4])
        4'h0: begin
          case (w_addr[3:0])
            C_ADDR_CTRL[3:0]:   w_live = {6'b0, r_freeze, 1'b0};
            C_ADDR_CH_SEL[3:0]: w_live = r_ch_sel;
            C_ADDR_STATUS[3:0]: if (w_ch_ok) w_live = w_status[w_ch];
            C_ADDR_HI_NUM[3:0]: if (w_ch_ok) w_live = {4'b0, w_hi_num[w_ch]};
            C_ADDR_LO_NUM[3:0]: if (w_ch_ok) w_live = {4'b0, w_lo_num[w_ch]};
            default: ;
          endcase
        end
        C_ADDR_HI_HIST[7:4], C_ADDR_LO_HIST[7:4]: begin
          w_is_pair = 1'b1;
          if (w_ch_ok) w_pair = 16'(w_hist8[w_addr[3:1]]);
        end
        C_ADDR_MINMAX[7:4]: begin
          if (!w_addr[3]) begin
            w_is_pair = 1'b1;
            if (w_ch_ok) begin
              case (w_addr[2:1])
                2'd0:    w_pair = 16'(w_hi_max[w_ch]);
                2'd1:    w_pair = 16'(w_hi_min[w_ch]);
                2'd2:    w_pair = 16'(w_lo_max[w_ch]);
                default: w_pair = 16'(w_lo_min[w_ch]);
              endcase
            end
          end
        end
        default: ;
      endcase
    end
    if (w_is_pair) w_live = w_addr[0] ? w_pair[15:8] : w_pair[7:0];
  end

  assign w_is_low     = w_is_pair & ~w_addr[0];
  assign w_shadow_hit = w_is_pair & w_addr[0] & r_shadow_vld & (r_shadow_tag == w_addr[7:1]);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_freeze     <= 1'b0;
      r_ch_sel     <= '0;
      oRD          <= '0;
      r_shadow     <= '0;
      r_shadow_tag <= '0;
      r_shadow_vld <= 1'b0;
    end else begin
      if (w_wr_ctrl)  r_freeze <= iDATA[C_CTRL_FREEZE];
      if (w_wr_chsel) r_ch_sel <= iDATA;
      if (iRE) begin
        oRD          <= w_shadow_hit ? r_shadow : w_live;
        // Only the read immediately following an L read may use the shadow
        r_shadow_vld <= w_is_low;
        if (w_is_low) begin
          r_shadow     <= w_pair[15:8];
          r_shadow_tag <= w_addr[7:1];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dbg_pulse_width_mon.sv
// ============================================================================
//  Module   : tb_dbg_pulse_width_mon
//  Purpose  : Directed, table-driven bench for the pulse-width monitor.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dbg_pulse_width_mon;

  logic       CLK;
  logic       RST;
  logic [7:0] iADDR;
  logic       iWE;
  logic       iRE;
  logic [7:0] iDATA;
  logic [7:0] oRD;
  logic [3:0] iSIG;

  int passed = 0;
  int total  = 0;

  typedef struct {
    int         phase;
    logic [7:0] ch;
    logic [7:0] addr;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  dbg_pulse_width_mon #(
    .N_CH        (4),
    .CNT_W       (12),
    .DEPTH       (4),
    .SYNC_STAGES (2),
    .ADDR_W      (8)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .iADDR (iADDR),
    .iWE   (iWE),
    .iRE   (iRE),
    .iDATA (iDATA),
    .oRD   (oRD),
    .iSIG  (iSIG)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: read %02h, expected %02h", name, act, exp);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    iADDR = a; iDATA = d; iWE = 1'b1;
    tick();
    iWE = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    iADDR = a; iRE = 1'b1;
    tick();
    iRE = 1'b0;
    d = oRD;
  endtask

  task automatic pulse(input int ch, input int hi, input int lo);
    iSIG[ch] = 1'b1;
    repeat (hi) tick();
    iSIG[ch] = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic add(input int p, input logic [7:0] ch, input logic [7:0] a, input logic [7:0] e);
    vec_t v;
    v.phase = p; v.ch = ch; v.addr = a; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic run_phase(input int p);
    logic [7:0] d;
    foreach (vecs[i]) begin
      if (vecs[i].phase == p) begin
        wr(8'h01, vecs[i].ch);
        rd(vecs[i].addr, d);
        check($sformatf("p%0d_ch%0d_a%02h", p, vecs[i].ch, vecs[i].addr), d, vecs[i].exp);
      end
    end
  endtask

  initial begin
    logic [7:0] d;

    // 0: after reset
    add(0, 0, 8'h32, 8'hFF); add(0, 0, 8'h33, 8'h0F); add(0, 0, 8'h02, 8'h00);
    add(0, 0, 8'h00, 8'h00); add(0, 0, 8'h03, 8'h00); add(0, 0, 8'h30, 8'h00);
    add(0, 0, 8'h36, 8'hFF); add(0, 0, 8'h37, 8'h0F);
    // 1: ch0 high10 low7 high10 low7
    add(1, 0, 8'h10, 8'h0A); add(1, 0, 8'h11, 8'h00); add(1, 0, 8'h12, 8'h0A);
    add(1, 0, 8'h14, 8'h00); add(1, 0, 8'h20, 8'h07); add(1, 0, 8'h22, 8'h00);
    add(1, 0, 8'h03, 8'h02); add(1, 0, 8'h04, 8'h01); add(1, 0, 8'h02, 8'hC0);
    add(1, 0, 8'h30, 8'h0A); add(1, 0, 8'h32, 8'h0A); add(1, 0, 8'h34, 8'h07);
    add(1, 0, 8'h36, 8'h07);
    // 2: ch1 saturating high phase
    add(2, 1, 8'h10, 8'hFF); add(2, 1, 8'h11, 8'h0F); add(2, 1, 8'h02, 8'hD0);
    add(2, 1, 8'h30, 8'hFF); add(2, 1, 8'h31, 8'h0F); add(2, 1, 8'h32, 8'hFF);
    add(2, 1, 8'h03, 8'h01);
    // 3: frozen 3-cycle pulse on ch1
    add(3, 1, 8'h00, 8'h02); add(3, 1, 8'h10, 8'hFF); add(3, 1, 8'h11, 8'h0F);
    add(3, 1, 8'h32, 8'hFF); add(3, 1, 8'h03, 8'h01);
    // 4: unfrozen 3-cycle pulse on ch1
    add(4, 1, 8'h00, 8'h00); add(4, 1, 8'h10, 8'h03); add(4, 1, 8'h11, 8'h00);
    add(4, 1, 8'h12, 8'hFF); add(4, 1, 8'h32, 8'h03); add(4, 1, 8'h33, 8'h00);
    add(4, 1, 8'h03, 8'h02);
    // 5: ch3 widths 1..6, gaps of 4
    add(5, 3, 8'h10, 8'h06); add(5, 3, 8'h12, 8'h05); add(5, 3, 8'h14, 8'h04);
    add(5, 3, 8'h16, 8'h03); add(5, 3, 8'h18, 8'h00); add(5, 3, 8'h03, 8'h04);
    add(5, 3, 8'h30, 8'h06); add(5, 3, 8'h32, 8'h01); add(5, 3, 8'h20, 8'h04);
    add(5, 3, 8'h04, 8'h04);
    // 6: after clear coincident with a fall on ch0
    add(6, 0, 8'h02, 8'h00); add(6, 0, 8'h03, 8'h00); add(6, 0, 8'h04, 8'h00);
    add(6, 0, 8'h10, 8'h00); add(6, 0, 8'h30, 8'h00); add(6, 0, 8'h32, 8'hFF);
    add(6, 1, 8'h02, 8'h00); add(6, 1, 8'h03, 8'h00); add(6, 3, 8'h03, 8'h00);
    // 7: unmapped / out-of-range entries
    add(7, 0, 8'h40, 8'h00); add(7, 0, 8'h05, 8'h00); add(7, 0, 8'h38, 8'h00);
    add(7, 0, 8'h1F, 8'h00);

    RST = 1'b1; iADDR = '0; iWE = 1'b0; iRE = 1'b0; iDATA = '0; iSIG = '0;
    repeat (4) tick();
    RST = 1'b0;
    check("rst_ord", oRD, 8'h00);
    run_phase(0);

    pulse(0, 10, 7);
    pulse(0, 10, 7);
    repeat (5) tick();
    run_phase(1);

    pulse(1, 5000, 6);
    run_phase(2);

    wr(8'h00, 8'h02);
    pulse(1, 3, 6);
    run_phase(3);
    wr(8'h00, 8'h00);
    pulse(1, 3, 6);
    run_phase(4);

    for (int w = 1; w <= 6; w++) pulse(3, w, 4);
    repeat (5) tick();
    run_phase(5);

    // CLR lands on the same edge the synchronised fall is acted on
    iSIG[0] = 1'b1;
    repeat (8) tick();
    iSIG[0] = 1'b0;
    tick();
    tick();
    wr(8'h00, 8'h01);
    repeat (4) tick();
    run_phase(6);

    // Coherent L/H read of hi max across an update 0x123 -> 0x200
    wr(8'h01, 8'h02);
    pulse(2, 291, 6);
    iSIG[2] = 1'b1;
    repeat (512) tick();
    iSIG[2] = 1'b0;
    rd(8'h30, d); check("coh_lo", d, 8'h23);
    repeat (5) tick();
    rd(8'h31, d); check("coh_hi_shadow", d, 8'h01);
    rd(8'h31, d); check("coh_hi_live", d, 8'h02);
    rd(8'h30, d); check("coh_lo_new", d, 8'h00);

    run_phase(7);

    // Out-of-range channel select, read+write in one cycle, oRD hold
    wr(8'h01, 8'h05);
    rd(8'h01, d); check("chsel_rb", d, 8'h05);
    rd(8'h32, d); check("chsel_oor_min", d, 8'h00);
    rd(8'h02, d); check("chsel_oor_stat", d, 8'h00);
    iADDR = 8'h01; iDATA = 8'h02; iWE = 1'b1; iRE = 1'b1;
    tick();
    iWE = 1'b0; iRE = 1'b0;
    check("rw_pre_write", oRD, 8'h05);
    repeat (3) tick();
    check("ord_hold", oRD, 8'h05);
    rd(8'h01, d); check("rw_post_write", d, 8'h02);
    rd(8'h30, d); check("ch2_max_lo", d, 8'h00);
    rd(8'h31, d); check("ch2_max_hi", d, 8'h02);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
